// File: rtl/gprf_sb_if.sv
// gprf_sb_if: decode/writeback-side bundle of the gprf_sb register file and scoreboard.
interface gprf_sb_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int AW = $clog2(DEPTH);
    logic             en;
    logic [AW-1:0]    writeAddr;
    logic [WIDTH-1:0] data;
    logic             sb_set;
    logic [AW-1:0]    sb_addr;
    logic [AW-1:0]    A_addr;
    logic [WIDTH-1:0] A;
    logic             A_busy;
    logic [AW-1:0]    B_addr;
    logic [WIDTH-1:0] B;
    logic             B_busy;
    logic [AW:0]      busy_cnt;
    logic             sb_err;
    modport master (
        output en, writeAddr, data, sb_set, sb_addr, A_addr, B_addr,
        input  A, A_busy, B, B_busy, busy_cnt, sb_err
    );
    modport slave (
        input  en, writeAddr, data, sb_set, sb_addr, A_addr, B_addr,
        output A, A_busy, B, B_busy, busy_cnt, sb_err
    );
endinterface

// File: rtl/gprf_sb.sv
// gprf_sb: 2R/1W register file with per-register busy scoreboard.
// Define GPRF_BYPASS_EN to forward the write port onto same-cycle reads.
module gprf_sb #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    gprf_sb_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [AW:0]      r_cnt;
    logic             r_err;
    logic [DEPTH-1:0] w_clr;
    logic [DEPTH-1:0] w_set;
    logic [DEPTH-1:0] w_busy_nxt;
    logic [AW:0]      w_cnt_nxt;
    logic             w_err_hit;
    logic             w_fwd_a;
    logic             w_fwd_b;

    // Set is ORed in after the clear so a new producer wins over the completing one.
    assign w_clr      = bus.en ? DEPTH'(1) << bus.writeAddr : '0;
    assign w_set      = bus.sb_set ? DEPTH'(1) << bus.sb_addr : '0;
    assign w_busy_nxt = (r_busy & ~w_clr) | w_set;
    // A completing write to the same register legitimises a re-issue.
    assign w_err_hit  = bus.sb_set && r_busy[bus.sb_addr] &&
                        !(bus.en && bus.writeAddr == bus.sb_addr);

    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++)
            w_cnt_nxt = w_cnt_nxt + (AW+1)'(w_busy_nxt[i]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++)
                r_regs[i] <= '0;
            r_busy <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else begin
            if (bus.en)
                r_regs[bus.writeAddr] <= bus.data;
            r_busy <= w_busy_nxt;
            r_cnt  <= w_cnt_nxt;
            r_err  <= r_err | w_err_hit;
        end
    end

`ifdef GPRF_BYPASS_EN
    assign w_fwd_a = bus.en && bus.A_addr == bus.writeAddr;
    assign w_fwd_b = bus.en && bus.B_addr == bus.writeAddr;
`else
    assign w_fwd_a = 1'b0;
    assign w_fwd_b = 1'b0;
`endif

    // Forwarded reads hide the clearing write's busy bit unless it is re-issued now.
    assign bus.A      = w_fwd_a ? bus.data : r_regs[bus.A_addr];
    assign bus.B      = w_fwd_b ? bus.data : r_regs[bus.B_addr];
    assign bus.A_busy = w_fwd_a ? (bus.sb_set && bus.sb_addr == bus.A_addr && r_busy[bus.A_addr])
                                : r_busy[bus.A_addr];
    assign bus.B_busy = w_fwd_b ? (bus.sb_set && bus.sb_addr == bus.B_addr && r_busy[bus.B_addr])
                                : r_busy[bus.B_addr];
    assign bus.busy_cnt = r_cnt;
    assign bus.sb_err   = r_err;
endmodule

// File: tb/tb_gprf_sb.sv
// tb_gprf_sb: directed and random checks of gprf_sb against an array-based reference model.
module tb_gprf_sb;
`ifdef GPRF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset_n;
    int   vectors = 0;
    int   errs = 0;
    logic [7:0] m_regs [8];
    bit   [7:0] m_busy;
    bit         m_err;

    gprf_sb_if #(.WIDTH(8), .DEPTH(8)) bus ();
    gprf_sb #(.WIDTH(8), .DEPTH(8)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_rd(input logic [2:0] a);
        return (BYP && bus.en && a == bus.writeAddr) ? bus.data : m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [2:0] a);
        if (BYP && bus.en && a == bus.writeAddr)
            return bus.sb_set && bus.sb_addr == a && m_busy[a];
        return m_busy[a];
    endfunction

    task automatic check_all();
        check("A", bus.A, exp_rd(bus.A_addr));
        check("B", bus.B, exp_rd(bus.B_addr));
        check("A_busy", bus.A_busy, exp_busy(bus.A_addr));
        check("B_busy", bus.B_busy, exp_busy(bus.B_addr));
        check("busy_cnt", bus.busy_cnt, $countones(m_busy));
        check("sb_err", bus.sb_err, m_err);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_busy = '0;
        m_err  = 1'b0;
    endtask

    task automatic model_tick();
        if (bus.sb_set && m_busy[bus.sb_addr] && !(bus.en && bus.writeAddr == bus.sb_addr))
            m_err = 1'b1;
        if (bus.en) begin
            m_regs[bus.writeAddr] = bus.data;
            m_busy[bus.writeAddr] = 1'b0;
        end
        if (bus.sb_set) m_busy[bus.sb_addr] = 1'b1;
    endtask

    task automatic drv(input logic en, input logic [2:0] wa, input logic [7:0] d,
                       input logic set, input logic [2:0] sa,
                       input logic [2:0] aa, input logic [2:0] ba);
        bus.en = en; bus.writeAddr = wa; bus.data = d;
        bus.sb_set = set; bus.sb_addr = sa; bus.A_addr = aa; bus.B_addr = ba;
    endtask

    task automatic cyc();
        #3;
        check_all();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic do_reset();
        bus.en = 1'b0; bus.sb_set = 1'b0;
        reset_n = 1'b0;
        #1;
        model_clear();
        check("rst_A", bus.A, 8'h00);
        check("rst_cnt", bus.busy_cnt, 0);
        check("rst_err", bus.sb_err, 0);
        check_all();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0);
        model_clear();
        #2;
        check_all();
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        drv(1, 3, 8'hA5, 0, 0, 3, 3); cyc();
        drv(0, 0, 0, 0, 0, 3, 3);
        #2;
        check("pre_rst_A", bus.A, 8'hA5);
        do_reset();

        drv(1, 1, 8'h3C, 0, 0, 0, 0); cyc();
        drv(1, 7, 8'hFF, 0, 0, 0, 0); cyc();
        drv(0, 0, 0, 0, 0, 1, 7);
        #3;
        check("wr_A", bus.A, 8'h3C);
        check("wr_B", bus.B, 8'hFF);
        check("wr_Abusy", bus.A_busy, 0);
        check("wr_Bbusy", bus.B_busy, 0);
        cyc();

        drv(0, 0, 0, 1, 2, 2, 2); cyc();
        drv(0, 0, 0, 0, 0, 2, 2);
        check("sb_Abusy", bus.A_busy, 1);
        check("sb_cnt1", bus.busy_cnt, 1);
        cyc(); cyc();
        drv(1, 2, 8'h11, 0, 0, 2, 2); cyc();
        drv(0, 0, 0, 0, 0, 2, 2);
        check("clr_Abusy", bus.A_busy, 0);
        check("clr_A", bus.A, 8'h11);
        check("clr_cnt0", bus.busy_cnt, 0);
        cyc();

        drv(0, 0, 0, 1, 4, 4, 4); cyc();
        drv(1, 4, 8'h22, 1, 4, 4, 4); cyc();
        drv(0, 0, 0, 0, 0, 4, 4);
        check("sim_busy", bus.A_busy, 1);
        check("sim_cnt", bus.busy_cnt, 1);
        check("sim_err0", bus.sb_err, 0);
        cyc();
        drv(0, 0, 0, 1, 4, 4, 4); cyc();
        drv(0, 0, 0, 0, 0, 4, 4);
        check("err_set", bus.sb_err, 1);
        cyc(); cyc();
        check("err_sticky", bus.sb_err, 1);

        for (int i = 0; i < 8; i++) begin
            drv(0, 0, 0, 1, 3'(i), 3'(i), 3'(7 - i)); cyc();
        end
        drv(0, 0, 0, 0, 0, 0, 0);
        check("full_cnt8", bus.busy_cnt, 8);
        for (int i = 0; i < 8; i++) begin
            drv(1, 3'(i), 8'(i * 17), 0, 0, 3'(i), 0); cyc();
        end
        drv(0, 0, 0, 0, 0, 0, 0);
        check("empty_cnt0", bus.busy_cnt, 0);
        cyc();

        drv(0, 0, 0, 1, 5, 5, 5); cyc();
        drv(1, 5, 8'h77, 0, 0, 5, 5);
        #2;
        check("byp_A", bus.A, BYP ? 8'h77 : 8'h55);
        check("byp_Abusy", bus.A_busy, BYP ? 0 : 1);
        cyc();
        drv(0, 0, 0, 0, 0, 5, 5);
        check("post_A", bus.A, 8'h77);
        check("post_Abusy", bus.A_busy, 0);
        cyc();

        for (int n = 0; n < 400; n++) begin
            if (n == 200) do_reset();
            drv($urandom_range(1) == 1, 3'($urandom_range(7)), 8'($urandom),
                $urandom_range(2) == 0, 3'($urandom_range(7)),
                3'($urandom_range(7)), 3'($urandom_range(7)));
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/gprf_sb.md
# gprf_sb

Parametrised general-purpose register file with a per-register busy scoreboard, the next generation of the Ra8 8×8 register file. It provides two combinational read ports, one synchronous write port and a scoreboard issue port, so the control unit can stall on registers with a pending multi-cycle result (memory load, multiply). It sits between the decode stage (read/issue) and the writeback mux (write).

## Interface
- `WIDTH`, 8: data width of each register, ≥1
- `DEPTH`, 8: number of registers, power of two, ≥2; `AW = $clog2(DEPTH)` is a localparam
- `clk` input 1: the block's single clock, rising-edge active
- `reset_n` input 1: reset, asynchronous, active-low
- `en` input 1: write enable
- `writeAddr` input AW: write address
- `data` input WIDTH: write data
- `sb_set` input 1: mark `sb_addr` busy (pending producer issued)
- `sb_addr` input AW: scoreboard issue address
- `A_addr` input AW: read address, port A
- `A` output WIDTH: read data, port A
- `A_busy` output 1: register at `A_addr` is busy
- `B_addr` input AW: read address, port B
- `B` output WIDTH: read data, port B
- `B_busy` output 1: register at `B_addr` is busy
- `busy_cnt` output AW+1: number of busy registers
- `sb_err` output 1: sticky flag, set when `sb_set` targets an already-busy register

## Operation
- Storage: DEPTH×WIDTH flops. No tri-states; every address is in range by construction.
- Write: at a rising edge of `clk` with `en`=1, `regs[writeAddr] <= data`. Writes are always accepted, busy or not.
- Scoreboard: one busy bit per register.
  - `en` && !`sb_set`: clear `busy[writeAddr]`.
  - `sb_set` && !`en`: set `busy[sb_addr]`.
  - Both, different addresses: clear one, set the other.
  - Both, same address: set wins (new producer supersedes the completing one); busy stays/becomes 1.
- Error: `sb_set` while `busy[sb_addr]`=1 and that bit is not cleared in the same cycle sets `sb_err`. It stays set until reset. The bit stays 1 and `busy_cnt` is unchanged.
- `busy_cnt`: registered count, kept equal to popcount(busy) every cycle. It ranges 0..DEPTH and never wraps.
- Reads: `A = regs[A_addr]`, `A_busy = busy[A_addr]`; port B is identical. Both are combinational from the current state, apart from the bypass below.

## Timing
- Reset (`reset_n`=0, asynchronous): all registers 0, all busy bits 0, `busy_cnt`=0, `sb_err`=0. Outputs reflect this immediately, with no clock required. Reset in the middle of a pending operation discards all pending state. Deassertion is synchronised externally.
- Write latency: data is visible on A/B in the cycle after the edge (1 cycle), or in the same cycle with bypass.
- Busy set: `A_busy` rises in the cycle after the `sb_set` edge. It is never bypassed.
- Busy clear: `A_busy` falls in the cycle after the completing write, or in the same cycle with bypass (see Configuration).
- A and B may read the same address, and may read the address being written. Both ports return identical values.

## Configuration
- `GPRF_BYPASS_EN` defined: write-to-read forwarding is enabled.
  - When `en`=1 and `A_addr`==`writeAddr`, `A`=`data` in the same cycle.
  - In that case `A_busy`=0, unless `sb_set`=1 to the same address in the same cycle, in which case `A_busy`=`busy[A_addr]`.
  - Port B behaves the same way.
- `GPRF_BYPASS_EN` undefined: reads always come from stored state, with the 1-cycle write-to-read latency above.

## Test plan
- Reset: write 0xA5 to r3, then assert `reset_n`=0 with no clock edge → `A`=0x00 with `A_addr`=3 immediately; `busy_cnt`=0; `sb_err`=0.
- Write/read: write r1=0x3C, then r7=0xFF; in the next cycle `A_addr`=1, `B_addr`=7 → `A`=0x3C, `B`=0xFF; both `A_busy` and `B_busy` = 0.
- Scoreboard: `sb_set` r2 → next cycle `A_busy`=1, `busy_cnt`=1. Write r2=0x11 two cycles later → next cycle `A_busy`=0, `A`=0x11, `busy_cnt`=0.
- Simultaneous: r4 busy; in one cycle `en`=1 and `sb_set`=1 to r4 → r4 stays busy, `busy_cnt` unchanged, `sb_err`=0. Then `sb_set` r4 again → `sb_err`=1 and stays 1.
- Full: `sb_set` all 8 registers on consecutive cycles → `busy_cnt`=8. Then write all 8 → `busy_cnt` returns to 0 with no wrap.
- Bypass: with the macro defined, write r5=0x77 with `A_addr`=5 while r5 is busy → same cycle `A`=0x77, `A_busy`=0. With the macro undefined → old value and `A_busy`=1 that cycle, then 0x77 and 0 the next cycle.
